// File: rtl/chip8_pkg.sv
// -----------------------------------------------------------------------------
// chip8_pkg
// Shared constants and types for the CHIP-8 GPU draw path.
//   FB_W / FB_H       : framebuffer size in pixels (64 x 32, monochrome)
//   FB_ROW_BYTES      : bytes per framebuffer row (MSB = leftmost pixel)
//   FB_BASE_DEFAULT   : default byte address of framebuffer row 0, byte 0
//   draw_state_t      : sprite draw FSM states
// -----------------------------------------------------------------------------
package chip8_pkg;

    localparam int FB_W         = 64;
    localparam int FB_H         = 32;
    localparam int FB_ROW_BYTES = 8;

    localparam logic [11:0] FB_BASE_DEFAULT = 12'hF00;

    typedef enum logic [3:0] {
        IDLE,
        SPR_REQ,
        SPR_WAIT,
        FB0_REQ,
        FB0_WAIT,
        FB0_WR,
        FB1_REQ,
        FB1_WAIT,
        FB1_WR,
        DONE
    } draw_state_t;

endpackage

// File: rtl/sprite_drawer.sv
// -----------------------------------------------------------------------------
// sprite_drawer
// Draw engine for the CHIP-8 DXYN instruction. Fetches N sprite bytes starting
// at I and XORs them into the framebuffer held in main memory, reporting
// whether any lit pixel was cleared.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   start               : one-cycle draw request (accepted only when idle)
//   x, y, n, i_addr     : Vx, Vy, sprite height, sprite base address
//   busy                : draw in progress
//   done                : one-cycle completion pulse
//   collision           : VF result, valid from done until the next start
//   mem_read / _addr    : one-cycle read request and address
//   mem_read_data / _ack: read data, valid while ack is high
//   mem_write / _addr / _data : one-cycle write strobe, address, data
// -----------------------------------------------------------------------------
module sprite_drawer
    import chip8_pkg::*;
#(
    parameter logic [11:0] FB_BASE = FB_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    input  logic [3:0]  n,
    input  logic [11:0] i_addr,
    output logic        busy,
    output logic        done,
    output logic        collision,
    output logic        mem_read,
    output logic [11:0] mem_read_addr,
    input  logic [7:0]  mem_read_data,
    input  logic        mem_read_ack,
    output logic        mem_write,
    output logic [11:0] mem_write_addr,
    output logic [7:0]  mem_write_data
);

    draw_state_t r_state;
    draw_state_t w_next;

    logic [5:0]  r_x0;
    logic [4:0]  r_y0;
    logic [3:0]  r_n;
    logic [11:0] r_iaddr;
    logic [3:0]  r_row;
    logic [7:0]  r_spr;
    logic [7:0]  r_old;
    logic        r_collision;

    logic [2:0]  w_xb;
    logic [2:0]  w_xs;
    logic [7:0]  w_hi;
    logic [7:0]  w_lo;
    logic [4:0]  w_fb_row;
    logic [11:0] w_fb_addr0;
    logic [11:0] w_fb_addr1;
    logic [11:0] w_spr_addr;
    logic        w_has_lo;
    logic [4:0]  w_row_next;
    logic        w_rows_done;
    logic        w_row_end;
    logic        w_unused;

    // Vx/Vy wrap modulo 64/32, so their upper bits never matter.
    assign w_unused = &{1'b0, x[7:6], y[7:5]};

    assign w_xb = r_x0[5:3];
    assign w_xs = r_x0[2:0];

    // The sprite byte straddles two framebuffer bytes when xs != 0:
    // hi lands in column byte xb, lo spills into xb+1.
    assign w_hi = r_spr >> w_xs;
    assign w_lo = r_spr << (4'd8 - {1'b0, w_xs});

    // Only evaluated while drawing, when y0 + row is known to be < 32.
    assign w_fb_row   = r_y0 + {1'b0, r_row};
    assign w_fb_addr0 = FB_BASE + {4'b0000, w_fb_row, w_xb};
    assign w_fb_addr1 = w_fb_addr0 + 12'd1;
    assign w_spr_addr = r_iaddr + {8'b0000_0000, r_row};

    // Second byte is skipped when aligned or when it would fall off the right edge.
    assign w_has_lo = (w_xs != 3'd0) && (w_xb != 3'd7);

    // Row loop ends after n rows or at the bottom edge (clipped, not wrapped).
    assign w_row_next  = {1'b0, r_row} + 5'd1;
    assign w_rows_done = (w_row_next >= {1'b0, r_n}) ||
                         (({1'b0, r_y0} + {1'b0, w_row_next}) >= 6'(FB_H));

    assign w_row_end = ((r_state == FB0_WR) && !w_has_lo) || (r_state == FB1_WR);

    assign collision = r_collision;

    // Control state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_collision <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == IDLE) && start) begin
                r_collision <= 1'b0;
            end else if ((r_state == FB0_WAIT) && mem_read_ack) begin
                r_collision <= r_collision | (|(mem_read_data & w_hi));
            end else if ((r_state == FB1_WAIT) && mem_read_ack) begin
                r_collision <= r_collision | (|(mem_read_data & w_lo));
            end
        end
    end

    // Datapath registers: operands latched at start, bytes captured on ack
    always_ff @(posedge clk) begin
        if ((r_state == IDLE) && start) begin
            r_x0    <= x[5:0];
            r_y0    <= y[4:0];
            r_n     <= n;
            r_iaddr <= i_addr;
            r_row   <= 4'd0;
        end
        if ((r_state == SPR_WAIT) && mem_read_ack) begin
            r_spr <= mem_read_data;
        end
        if (((r_state == FB0_WAIT) || (r_state == FB1_WAIT)) && mem_read_ack) begin
            r_old <= mem_read_data;
        end
        if (w_row_end) begin
            r_row <= w_row_next[3:0];
        end
    end

    // Next state and Moore outputs
    always_comb begin
        w_next         = r_state;
        busy           = 1'b0;
        done           = 1'b0;
        mem_read       = 1'b0;
        mem_read_addr  = 12'h000;
        mem_write      = 1'b0;
        mem_write_addr = 12'h000;
        mem_write_data = 8'h00;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = (n == 4'd0) ? DONE : SPR_REQ;
                end
            end
            SPR_REQ: begin
                busy          = 1'b1;
                mem_read      = 1'b1;
                mem_read_addr = w_spr_addr;
                w_next        = SPR_WAIT;
            end
            SPR_WAIT: begin
                busy = 1'b1;
                if (mem_read_ack) begin
                    w_next = FB0_REQ;
                end
            end
            FB0_REQ: begin
                busy          = 1'b1;
                mem_read      = 1'b1;
                mem_read_addr = w_fb_addr0;
                w_next        = FB0_WAIT;
            end
            FB0_WAIT: begin
                busy = 1'b1;
                if (mem_read_ack) begin
                    w_next = FB0_WR;
                end
            end
            FB0_WR: begin
                busy           = 1'b1;
                mem_write      = 1'b1;
                mem_write_addr = w_fb_addr0;
                mem_write_data = r_old ^ w_hi;
                if (w_has_lo) begin
                    w_next = FB1_REQ;
                end else begin
                    w_next = w_rows_done ? DONE : SPR_REQ;
                end
            end
            FB1_REQ: begin
                busy          = 1'b1;
                mem_read      = 1'b1;
                mem_read_addr = w_fb_addr1;
                w_next        = FB1_WAIT;
            end
            FB1_WAIT: begin
                busy = 1'b1;
                if (mem_read_ack) begin
                    w_next = FB1_WR;
                end
            end
            FB1_WR: begin
                busy           = 1'b1;
                mem_write      = 1'b1;
                mem_write_addr = w_fb_addr1;
                mem_write_data = r_old ^ w_lo;
                w_next         = w_rows_done ? DONE : SPR_REQ;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sprite_drawer.sv
// -----------------------------------------------------------------------------
// tb_sprite_drawer
// Bench for sprite_drawer: a 4 KiB memory with a fixed one-cycle read ack, a
// pixel-level framebuffer reference model, directed cases and random draws.
// -----------------------------------------------------------------------------
module tb_sprite_drawer;

    localparam int TB_FB_BASE = 'hF00;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [3:0]  n;
    logic [11:0] i_addr;
    logic        busy;
    logic        done;
    logic        collision;
    logic        mem_read;
    logic [11:0] mem_read_addr;
    logic [7:0]  mem_read_data = 8'h00;
    logic        mem_read_ack  = 1'b0;
    logic        mem_write;
    logic [11:0] mem_write_addr;
    logic [7:0]  mem_write_data;

    bit [7:0] mem     [4096];
    bit [7:0] exp_mem [4096];

    logic        tb_we = 1'b0;
    logic [11:0] tb_wa = 12'h000;
    logic [7:0]  tb_wd = 8'h00;

    int rd_cnt   = 0;
    int wr_cnt   = 0;
    int both_cnt = 0;
    int tests    = 0;
    int fails    = 0;

    always #5 clk = ~clk;

    sprite_drawer dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .x              (x),
        .y              (y),
        .n              (n),
        .i_addr         (i_addr),
        .busy           (busy),
        .done           (done),
        .collision      (collision),
        .mem_read       (mem_read),
        .mem_read_addr  (mem_read_addr),
        .mem_read_data  (mem_read_data),
        .mem_read_ack   (mem_read_ack),
        .mem_write      (mem_write),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data)
    );

    // Memory block: one-cycle read ack, writes take effect at the strobe edge.
    always @(posedge clk) begin
        mem_read_ack  <= mem_read;
        mem_read_data <= mem[mem_read_addr];
        if (mem_write) mem[mem_write_addr] = mem_write_data;
        if (tb_we) mem[tb_wa] = tb_wd;
        if (mem_read) rd_cnt <= rd_cnt + 1;
        if (mem_write) wr_cnt <= wr_cnt + 1;
        if (mem_read && mem_write) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        tb_we = 1'b1;
        tb_wa = a;
        tb_wd = d;
        exp_mem[a] = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic check_mem(input string tag);
        int bad = 0;
        int first = -1;
        for (int a = 0; a < 4096; a++) begin
            if (mem[a] != exp_mem[a]) begin
                bad++;
                if (first < 0) first = a;
            end
        end
        check($sformatf("%s.mem_image(first_bad=%0h)", tag, first), bad, 0);
    endtask

    // Pixel-level reference: flips each lit sprite pixel on screen, clips at the
    // right and bottom edges, and derives cost from the bytes each row covers.
    task automatic model(input logic [7:0] mx, input logic [7:0] my, input logic [3:0] mn,
                         input logic [11:0] mia, output logic col, output int lat,
                         output int writes, output int reads);
        int x0, y0, row, px, a, first_b, last_b, nbytes;
        bit [7:0] spr, mask;
        x0 = int'(mx) % 64;
        y0 = int'(my) % 32;
        col = 1'b0;
        lat = 1;
        writes = 0;
        reads = 0;
        for (int r = 0; r < int'(mn); r++) begin
            row = y0 + r;
            if (row >= 32) break;
            spr = exp_mem[(int'(mia) + r) % 4096];
            for (int b = 0; b < 8; b++) begin
                px = x0 + b;
                if (px < 64 && spr[7 - b]) begin
                    a = TB_FB_BASE + row * 8 + px / 8;
                    mask = 8'h80 >> (px % 8);
                    if ((exp_mem[a] & mask) != 0) col = 1'b1;
                    exp_mem[a] = exp_mem[a] ^ mask;
                end
            end
            first_b = x0 / 8;
            last_b = ((x0 + 7 > 63) ? 63 : x0 + 7) / 8;
            nbytes = last_b - first_b + 1;
            lat += 2 + 3 * nbytes;
            writes += nbytes;
            reads += 1 + nbytes;
        end
    endtask

    // Called at a negedge. const_lat < 0 means no fixed latency to check.
    task automatic draw(input logic [7:0] dx, input logic [7:0] dy, input logic [3:0] dn,
                        input logic [11:0] dia, input bit glitch, input int const_lat,
                        input string tag);
        logic ecol;
        int elat, ew, er, rd0, wr0, bo0, cyc;
        model(dx, dy, dn, dia, ecol, elat, ew, er);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        bo0 = both_cnt;
        x = dx;
        y = dy;
        n = dn;
        i_addr = dia;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check({tag, ".busy_first"}, busy, (dn != 4'd0));
        while (done !== 1'b1 && cyc < 300) begin
            if (glitch && cyc == 2) begin
                start = 1'b1;
                x = 8'($urandom);
                y = 8'($urandom);
                n = 4'($urandom);
                i_addr = 12'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, ".done"}, done, 1);
        check({tag, ".latency"}, cyc, elat);
        if (const_lat >= 0) check({tag, ".latency_fixed"}, cyc, const_lat);
        check({tag, ".busy_at_done"}, busy, 0);
        check({tag, ".collision"}, collision, ecol);
        @(negedge clk);
        check({tag, ".done_pulse"}, done, 0);
        check({tag, ".collision_hold"}, collision, ecol);
        check({tag, ".writes"}, wr_cnt - wr0, ew);
        check({tag, ".reads"}, rd_cnt - rd0, er);
        check({tag, ".rd_wr_overlap"}, both_cnt - bo0, 0);
        check_mem(tag);
    endtask

    initial begin
        int wr0;
        logic [7:0] rx, ry;
        logic [3:0] rn;
        logic [11:0] ria;

        rst = 1'b1;
        start = 1'b0;
        x = 8'h00;
        y = 8'h00;
        n = 4'h0;
        i_addr = 12'h000;
        repeat (3) @(negedge clk);

        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.collision", collision, 0);
        check("reset.mem_read", mem_read, 0);
        check("reset.mem_write", mem_write, 0);
        check("reset.mem_read_addr", mem_read_addr, 0);
        check("reset.mem_write_addr", mem_write_addr, 0);
        check("reset.mem_write_data", mem_write_data, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int a = TB_FB_BASE; a < 4096; a++) poke(12'(a), 8'($urandom));

        poke(12'h200, 8'hF0);
        poke(12'hF01, 8'h00);
        draw(8'd8, 8'd0, 4'd1, 12'h200, 1'b0, 6, "aligned");
        check("aligned.byte", mem[12'hF01], 8'hF0);

        poke(12'h210, 8'hFF);
        poke(12'hF10, 8'h00);
        poke(12'hF11, 8'h00);
        draw(8'd3, 8'd2, 4'd1, 12'h210, 1'b0, 9, "unaligned");
        check("unaligned.byte0", mem[12'hF10], 8'h1F);
        check("unaligned.byte1", mem[12'hF11], 8'hE0);

        draw(8'd3, 8'd2, 4'd1, 12'h210, 1'b1, 9, "erase");
        check("erase.byte0", mem[12'hF10], 8'h00);
        check("erase.byte1", mem[12'hF11], 8'h00);
        check("erase.collision", collision, 1);

        poke(12'h220, 8'hFF);
        poke(12'h221, 8'hFF);
        poke(12'h222, 8'hFF);
        poke(12'hFFF, 8'h00);
        draw(8'd60, 8'd31, 4'd3, 12'h220, 1'b0, 6, "clip");
        check("clip.byte", mem[12'hFFF], 8'h0F);

        poke(12'h230, 8'hA5);
        poke(12'h231, 8'h3C);
        draw(8'd70, 8'd5, 4'd2, 12'h230, 1'b0, -1, "wrap_x70");
        draw(8'd6, 8'd5, 4'd2, 12'h230, 1'b0, -1, "wrap_x6");
        check("wrap.same_pixels", collision, 1);

        draw(8'd10, 8'd10, 4'd0, 12'h200, 1'b0, 1, "n0");

        // Reset during FB0_WAIT of row 0.
        poke(12'hF10, 8'h5A);
        wr0 = wr_cnt;
        x = 8'd3;
        y = 8'd2;
        n = 4'd1;
        i_addr = 12'h210;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rst_mid.spr_read", mem_read, 1);
        check("rst_mid.spr_addr", mem_read_addr, 12'h210);
        @(negedge clk);
        @(negedge clk);
        check("rst_mid.fb_read", mem_read, 1);
        check("rst_mid.fb_addr", mem_read_addr, 12'hF10);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid.busy", busy, 0);
        check("rst_mid.done", done, 0);
        check("rst_mid.mem_write", mem_write, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_mid.no_writes", wr_cnt - wr0, 0);
        check("rst_mid.collision", collision, 0);
        check_mem("rst_mid");

        for (int t = 0; t < 24; t++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            rn = 4'($urandom);
            ria = 12'($urandom_range(0, 'hE00));
            for (int k = 0; k < int'(rn); k++) poke(ria + 12'(k), 8'($urandom));
            draw(rx, ry, rn, ria, 1'($urandom_range(0, 1)), -1, $sformatf("rand%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
